// File: rtl/mem_wb_stage_pkg.sv
// Shared decode constants, write-back select encodings, load funct3 codes
// and the MEM/WB stage register layout.
package mem_wb_stage_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        reg_we;
    wb_sel_e     wb_sel;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] pc_plus4;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment: picks the byte/halfword addressed by the low address
// bits and sign- or zero-extends it according to the load funct3.
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'b00: byte_sel = rdata[7:0];
      2'b01: byte_sel = rdata[15:8];
      2'b10: byte_sel = rdata[23:16];
      2'b11: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Halfword loads ignore offset[0]; misaligned halfwords are not split.
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    aligned = rdata;
    case (funct3)
      LB:      aligned = {{24{byte_sel[7]}}, byte_sel};
      LBU:     aligned = {24'h000000, byte_sel};
      LH:      aligned = {{16{half_sel[15]}}, half_sel};
      LHU:     aligned = {16'h0000, half_sel};
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers the MEM-stage result, selects and aligns
// the write-back value, drives the register-file write port and bypass.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_we_in,
  input  logic [1:0]  wb_sel_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] mem_rdata_in,
  input  logic [31:0] pc_plus4_in,
  input  logic        stall,
  input  logic        flush,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wd,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [31:0] retire_count
);

  mem_wb_t     stage;
  logic [31:0] retire_q;
  logic [31:0] load_data;

  // An entry retires on the edge it leaves the stage; a flush squashes it
  // uncounted even when it coincides with a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage    <= '0;
      retire_q <= '0;
    end else begin
      if (stage.valid && !stall && !flush)
        retire_q <= retire_q + 32'd1;
      if (!stall) begin
        stage.valid      <= valid_in;
        stage.rd         <= rd_in;
        stage.reg_we     <= reg_we_in;
        stage.wb_sel     <= wb_sel_e'(wb_sel_in);
        stage.funct3     <= funct3_in;
        stage.alu_result <= alu_result_in;
        stage.mem_rdata  <= mem_rdata_in;
        stage.pc_plus4   <= pc_plus4_in;
      end
      if (flush)
        stage.valid <= 1'b0;
    end
  end

  load_align u_load_align (
    .funct3  (stage.funct3),
    .offset  (stage.alu_result[1:0]),
    .rdata   (stage.mem_rdata),
    .aligned (load_data)
  );

  always_comb begin
    wd = stage.alu_result;
    case (stage.wb_sel)
      WB_MEM:  wd = load_data;
      WB_PC4:  wd = stage.pc_plus4;
      default: wd = stage.alu_result;
    endcase
  end

  // Combinational so the register file can write on the following negedge.
  assign we           = stage.valid & stage.reg_we & (stage.rd != 5'd0);
  assign waddr        = stage.rd;
  assign fwd_valid    = we;
  assign fwd_rd       = waddr;
  assign fwd_data     = wd;
  assign retire_count = retire_q;

endmodule
